// File: rtl/bcd_alu_pkg.sv
// bcd_alu_pkg: shared state encoding, op codes and width helpers for the sequential BCD ALU
package bcd_alu_pkg;
    typedef enum logic [2:0] {IDLE, CONVERT, EXEC, DABBLE, DONE} aluState;
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;
    function automatic int resultDigits(input int digits);
        return 2 * digits;
    endfunction
    function automatic int binWidth(input int digits);
        return 4 * digits;
    endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: serial double-dabble, one input bit per cycle; finished flags the final shift cycle
module bin_to_bcd_seq #(
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [2*BW-1:0] bin,
    output logic [2*BW-1:0] bcd,
    output logic            finished
);
    localparam int CW = $clog2(2 * BW + 1);
    logic [2*BW-1:0] shReg, adj;
    logic [CW-1:0] cnt;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BW / 2; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // Asserted while the last shift is in flight so the parent can leave DABBLE on the same edge
    assign finished = cnt == CW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shReg <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (load) begin
            shReg <= bin;
            bcd <= '0;
            cnt <= CW'(2 * BW);
        end else if (cnt != '0) begin
            bcd <= {adj[2*BW-2:0], shReg[2*BW-1]};
            shReg <= shReg << 1;
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: iterative packed-BCD add/sub/mul with start/done handshake, sign and error flags
module bcd_alu_seq
    import bcd_alu_pkg::*;
#(
    parameter int DIGITS = 2,
    localparam int RDIGITS = resultDigits(DIGITS),
    localparam int BW = binWidth(DIGITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*DIGITS-1:0]  operand_a,
    input  logic [4*DIGITS-1:0]  operand_b,
    input  logic [1:0]           op_sel,
    output logic                 busy,
    output logic                 done,
    output logic [4*RDIGITS-1:0] result,
    output logic                 negative,
    output logic                 error
);
    localparam int CW = $clog2(BW);
    aluState state;
    logic [BW-1:0] aReg, bReg, aBin, bBin, diff;
    logic [1:0] opReg;
    logic [2*BW-1:0] acc, accNext, execVal, bcdOut;
    logic [CW-1:0] cnt;
    logic negReg, errReg, badInput, load, finished;
    always_comb begin
        badInput = op_sel == OP_NONE;
        for (int i = 0; i < DIGITS; i++)
            badInput = badInput | (operand_a[4*i +: 4] > 4'd9) | (operand_b[4*i +: 4] > 4'd9);
    end
    // Multiplier bit cnt selects whether the shifted multiplicand joins the accumulator
    assign accNext = acc + (bBin[cnt] ? {{BW{1'b0}}, aBin} << cnt : '0);
    assign diff = aBin >= bBin ? aBin - bBin : bBin - aBin;
    assign execVal = opReg == OP_ADD ? {{BW{1'b0}}, aBin} + {{BW{1'b0}}, bBin}
                   : opReg == OP_SUB ? {{BW{1'b0}}, diff} : accNext;
    assign load = state == EXEC && (opReg != OP_MUL || cnt == CW'(BW - 1));
    bin_to_bcd_seq #(.BW(BW)) u_dabble (
        .clk(clk),
        .rst(rst),
        .load(load),
        .bin(execVal),
        .bcd(bcdOut),
        .finished(finished)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            negative <= 1'b0;
            error <= 1'b0;
            aReg <= '0;
            bReg <= '0;
            aBin <= '0;
            bBin <= '0;
            opReg <= OP_NONE;
            acc <= '0;
            cnt <= '0;
            negReg <= 1'b0;
            errReg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        aReg <= operand_a;
                        bReg <= operand_b;
                        opReg <= op_sel;
                        aBin <= '0;
                        bBin <= '0;
                        acc <= '0;
                        cnt <= '0;
                        errReg <= badInput;
                        state <= badInput ? DONE : CONVERT;
                    end
                end
                CONVERT: begin
                    aBin <= BW'(aBin * 10 + aReg[BW-1 -: 4]);
                    bBin <= BW'(bBin * 10 + bReg[BW-1 -: 4]);
                    aReg <= aReg << 4;
                    bReg <= bReg << 4;
                    cnt <= cnt == CW'(DIGITS - 1) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(DIGITS - 1)) state <= EXEC;
                end
                EXEC: begin
                    acc <= accNext;
                    cnt <= cnt + CW'(1);
                    negReg <= opReg == OP_SUB && aBin < bBin;
                    if (load) state <= DABBLE;
                end
                DABBLE: if (finished) state <= DONE;
                DONE: begin
                    done <= 1'b1;
                    result <= errReg ? '0 : bcdOut;
                    negative <= negReg & ~errReg;
                    error <= errReg;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: directed and random checks of bcd_alu_seq (DIGITS=1,2,3) against an integer model
module tb_bcd_alu_seq;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] startV = '0;
    logic [11:0] opA = '0, opB = '0;
    logic [1:0] opSel = '0;
    logic [2:0] busyV, doneV, negV, errV;
    logic [7:0] res1;
    logic [15:0] res2;
    logic [23:0] res3;
    logic [1:0] sel = 2'd1;
    logic busyS, doneS, negS, errS, sawDone;
    logic [23:0] resS;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    bcd_alu_seq #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .start(startV[0]), .operand_a(opA[3:0]),
        .operand_b(opB[3:0]), .op_sel(opSel), .busy(busyV[0]), .done(doneV[0]), .result(res1),
        .negative(negV[0]), .error(errV[0]));
    bcd_alu_seq #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .start(startV[1]), .operand_a(opA[7:0]),
        .operand_b(opB[7:0]), .op_sel(opSel), .busy(busyV[1]), .done(doneV[1]), .result(res2),
        .negative(negV[1]), .error(errV[1]));
    bcd_alu_seq #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst), .start(startV[2]), .operand_a(opA),
        .operand_b(opB), .op_sel(opSel), .busy(busyV[2]), .done(doneV[2]), .result(res3),
        .negative(negV[2]), .error(errV[2]));

    assign busyS = busyV[sel];
    assign doneS = doneV[sel];
    assign negS = negV[sel];
    assign errS = errV[sel];
    assign resS = sel == 2'd0 ? {16'h0, res1} : sel == 2'd1 ? {8'h0, res2} : res3;

    function automatic int bcd2int(input logic [11:0] v, input int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic bit isBcd(input logic [11:0] v, input int d);
        for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] int2bcd(input int v);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] randBcd(input int d);
        logic [11:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation end to end; inj>0 pulses a junk start that many edges after accept
    task automatic doOp(input int d, input logic [11:0] a, input logic [11:0] b,
                        input logic [1:0] op, input int inj);
        int ea, eb, er, lat, n;
        logic [23:0] expRes;
        logic expNeg, expErr, busyOk;
        string tag;
        ea = bcd2int(a, d);
        eb = bcd2int(b, d);
        expErr = op == 2'd0 || !isBcd(a, d) || !isBcd(b, d);
        er = op == 2'd1 ? ea + eb : op == 2'd2 ? (ea >= eb ? ea - eb : eb - ea) : ea * eb;
        expNeg = !expErr && op == 2'd2 && ea < eb;
        expRes = expErr ? 24'h0 : int2bcd(er);
        lat = expErr ? 1 : d + (op == 2'd3 ? 4 * d : 1) + 8 * d + 1;
        tag = $sformatf("d%0d op%0d a=%0h b=%0h", d, op, a, b);
        @(negedge clk);
        sel = 2'(d - 1);
        opA = a;
        opB = b;
        opSel = op;
        startV = 3'b001 << (d - 1);
        @(posedge clk);
        #1 startV = '0;
        busyOk = busyS;
        n = 0;
        while (n < 200 && !doneS) begin
            if (inj > 0 && n == inj) begin
                opA = 12'h999;
                opB = 12'h999;
                opSel = 2'd1;
                startV = 3'b001 << (d - 1);
            end else if (inj > 0 && n == inj + 1) startV = '0;
            @(posedge clk);
            #1 n++;
            busyOk &= busyS;
        end
        startV = '0;
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, resS, expRes);
        check({tag, " negative"}, negS, expNeg);
        check({tag, " error"}, errS, expErr);
        check({tag, " busy"}, busyOk, 1);
    endtask

    initial begin
        logic [11:0] a, b;
        logic [1:0] op;
        int r;
        #12;
        check("reset busy", busyS, 0);
        check("reset done", doneS, 0);
        check("reset result", resS, 0);
        check("reset negative", negS, 0);
        check("reset error", errS, 0);
        @(negedge clk) rst = 1'b0;
        doOp(2, 12'h045, 12'h037, 2'd1, 0);
        doOp(2, 12'h012, 12'h057, 2'd2, 0);
        doOp(2, 12'h057, 12'h057, 2'd2, 0);
        doOp(2, 12'h099, 12'h099, 2'd3, 0);
        doOp(2, 12'h000, 12'h099, 2'd3, 0);
        doOp(2, 12'h03A, 12'h001, 2'd1, 0);
        doOp(2, 12'h012, 12'h034, 2'd0, 0);
        doOp(2, 12'h012, 12'h034, 2'd3, 5);
        @(negedge clk);
        opA = 12'h099;
        opB = 12'h099;
        opSel = 2'd3;
        startV = 3'b010;
        @(posedge clk);
        #1 startV = '0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort result", resS, 0);
        check("abort busy", busyS, 0);
        check("abort done", doneS, 0);
        @(negedge clk) rst = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 sawDone |= doneS;
        end
        check("abort no done", sawDone, 0);
        doOp(2, 12'h045, 12'h037, 2'd1, 0);
        doOp(1, 12'h009, 12'h009, 2'd3, 0);
        doOp(1, 12'h003, 12'h008, 2'd2, 0);
        doOp(1, 12'h007, 12'h006, 2'd1, 0);
        doOp(3, 12'h999, 12'h999, 2'd3, 0);
        doOp(3, 12'h999, 12'h999, 2'd1, 0);
        doOp(3, 12'h123, 12'h456, 2'd2, 0);
        doOp(3, 12'h9F1, 12'h001, 2'd3, 0);
        for (int d = 1; d <= 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                a = randBcd(d);
                b = randBcd(d);
                op = 2'($urandom_range(1, 3));
                r = $urandom_range(0, 9);
                if (r == 0) op = 2'd0;
                if (r == 1) a[4 * $urandom_range(0, d - 1) +: 4] = 4'($urandom_range(10, 15));
                doOp(d, a, b, op, 0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
